// File: rtl/sopc_multi_timer.sv
// Multi-channel Avalon-MM interval timer: per-channel prescaler, down-counter, timeout irq and PWM compare.
// Latency: readdata is registered (1 clk after address); register writes take effect on the write edge.
// Backpressure: none; the slave accepts a write every cycle and never stalls the fabric.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   address           [CH_BITS+2:3] channel select, [2:0] register select
//   chipselect        Avalon slave select (write strobe = chipselect & ~write_n)
//   write_n           active-low write strobe
//   writedata         32-bit write data
//   readdata          registered read data, updated every clk from the address mux
//   irq               OR of irq_vec
//   irq_vec           per-channel interrupt (TO & ITO)
//   pwm_out           per-channel registered PWM output
module sopc_multi_timer #(
    parameter int CH_BITS      = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 99
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_BITS+2:0]      address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    irq,
    output logic [(2**CH_BITS)-1:0] irq_vec,
    output logic [(2**CH_BITS)-1:0] pwm_out
);
    localparam int NUM_CH = 2**CH_BITS;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_SNAP    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-channel state
    logic [CNT_W-1:0]  r_cnt     [NUM_CH];
    logic [CNT_W-1:0]  r_period  [NUM_CH];
    logic [CNT_W-1:0]  r_cmp     [NUM_CH];
    logic [CNT_W-1:0]  r_snap    [NUM_CH];
    logic [14:0]       r_pre_cnt [NUM_CH];
    logic [3:0]        r_pre     [NUM_CH];
    logic [NUM_CH-1:0] r_ito;
    logic [NUM_CH-1:0] r_cont;
    logic [NUM_CH-1:0] r_pwm_en;
    logic [NUM_CH-1:0] r_to;
    logic [NUM_CH-1:0] r_run;

    logic               w_wr;
    logic [CH_BITS-1:0] w_ch;
    logic [2:0]         w_reg;
    logic [14:0]        w_mask [NUM_CH];
    logic [NUM_CH-1:0]  w_tick;
    logic [NUM_CH-1:0]  w_expire;
    logic [NUM_CH-1:0]  w_sel;
    logic [31:0]        w_rdata;
    logic               w_unused_wd;

    assign w_wr  = chipselect & ~write_n;
    assign w_ch  = address[CH_BITS+2:3];
    assign w_reg = address[2:0];

    // Not every writedata bit lands in a register for every CNT_W.
    assign w_unused_wd = ^writedata;

    assign irq_vec = r_to & r_ito;
    assign irq     = |irq_vec;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // Prescaler terminal count is 2**PRE - 1; PRE = 0 gives mask 0, i.e. a tick every clk.
            w_mask[i]   = 15'((16'd1 << r_pre[i]) - 16'd1);
            w_tick[i]   = r_run[i] && (r_pre_cnt[i] == w_mask[i]);
            w_expire[i] = w_tick[i] && (r_cnt[i] == '0);
            w_sel[i]    = w_wr && (w_ch == CH_BITS'(i));
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_STATUS:  w_rdata = {30'd0, r_run[w_ch], r_to[w_ch]};
            REG_CONTROL: w_rdata = {20'd0, r_pre[w_ch], 3'd0, r_pwm_en[w_ch],
                                    2'd0, r_cont[w_ch], r_ito[w_ch]};
            REG_PERIOD:  w_rdata = 32'(r_period[w_ch]);
            REG_COMPARE: w_rdata = 32'(r_cmp[w_ch]);
            REG_SNAP:    w_rdata = 32'(r_snap[w_ch]);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            pwm_out  <= '0;
            r_ito    <= '0;
            r_cont   <= '0;
            r_pwm_en <= '0;
            r_to     <= '0;
            r_run    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]     <= CNT_RST;
                r_period[i]  <= CNT_RST;
                r_cmp[i]     <= '0;
                r_snap[i]    <= '0;
                r_pre_cnt[i] <= '0;
                r_pre[i]     <= '0;
            end
        end else begin
            readdata <= w_rdata;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= r_run[i] & r_pwm_en[i] & (r_cnt[i] < r_cmp[i]);

                // Timebase advance; bus writes below are later in the block so they
                // override (START beats a one-shot expiry, PERIOD load beats a tick).
                if (r_run[i]) begin
                    r_pre_cnt[i] <= w_tick[i] ? 15'd0 : r_pre_cnt[i] + 15'd1;
                end
                if (w_expire[i]) begin
                    r_cnt[i] <= r_period[i];
                    r_to[i]  <= 1'b1;
                    if (!r_cont[i]) begin
                        r_run[i] <= 1'b0;
                    end
                end else if (w_tick[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                end

                if (w_sel[i]) begin
                    case (w_reg)
                        REG_STATUS: begin
                            // A timeout on the same edge wins so no event is lost.
                            if (!w_expire[i]) begin
                                r_to[i] <= 1'b0;
                            end
                        end
                        REG_CONTROL: begin
                            r_ito[i]    <= writedata[0];
                            r_cont[i]   <= writedata[1];
                            r_pwm_en[i] <= writedata[4];
                            r_pre[i]    <= writedata[11:8];
                            if (writedata[2]) begin
                                r_run[i]     <= 1'b1;
                                r_pre_cnt[i] <= '0;
                            end else if (writedata[3]) begin
                                r_run[i] <= 1'b0;
                            end
                        end
                        REG_PERIOD: begin
                            r_period[i]  <= writedata[CNT_W-1:0];
                            r_cnt[i]     <= writedata[CNT_W-1:0];
                            r_run[i]     <= 1'b0;
                            r_pre_cnt[i] <= '0;
                        end
                        REG_COMPARE: r_cmp[i]  <= writedata[CNT_W-1:0];
                        REG_SNAP:    r_snap[i] <= r_cnt[i];
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sopc_multi_timer.sv
// Bench for sopc_multi_timer: directed scenarios plus random bus traffic against a reference model.
module tb_sopc_multi_timer;
    localparam int CH_BITS = 2;
    localparam int NCH     = 4;
    localparam int CNT_W   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [CH_BITS+2:0]   address;
    logic                 chipselect;
    logic                 write_n;
    logic [31:0]          writedata;
    logic [31:0]          readdata;
    logic                 irq;
    logic [NCH-1:0]       irq_vec;
    logic [NCH-1:0]       pwm_out;

    always #5 clk = ~clk;

    sopc_multi_timer #(.CH_BITS(CH_BITS), .CNT_W(CNT_W), .RESET_PERIOD(99)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: each channel is a down-counter stepped by prescaler ticks.
    longint m_cnt [NCH];
    longint m_per [NCH];
    longint m_cmp [NCH];
    longint m_snap[NCH];
    int     m_pc  [NCH];
    int     m_pre [NCH];
    bit     m_ito [NCH];
    bit     m_cont[NCH];
    bit     m_pen [NCH];
    bit     m_to  [NCH];
    bit     m_run [NCH];
    bit     m_pwm [NCH];
    logic [31:0] m_rd;

    function automatic logic [31:0] model_read(input int ch, input int rg);
        case (rg)
            0: return 32'(m_to[ch] + 2 * m_run[ch]);
            1: return 32'(m_pre[ch] * 256 + m_pen[ch] * 16 + m_cont[ch] * 2 + m_ito[ch]);
            2: return 32'(m_per[ch]);
            3: return 32'(m_cmp[ch]);
            4: return 32'(m_snap[ch]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] exp_irqv();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pwm();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_pwm[c];
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit wr, input int ch, input int rg,
                              input logic [31:0] wd);
        bit sel, tick, expire;
        if (rst) begin
            m_rd = 32'd0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 99; m_per[c] = 99; m_cmp[c] = 0; m_snap[c] = 0;
                m_pc[c] = 0; m_pre[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
                m_pen[c] = 0; m_to[c] = 0; m_run[c] = 0; m_pwm[c] = 0;
            end
            return;
        end
        m_rd = model_read(ch, rg);
        for (int c = 0; c < NCH; c++) begin
            sel    = wr && (ch == c);
            tick   = m_run[c] && (m_pc[c] == (1 << m_pre[c]) - 1);
            expire = tick && (m_cnt[c] == 0);
            m_pwm[c] = m_run[c] && m_pen[c] && (m_cnt[c] < m_cmp[c]);
            if (sel && rg == 4) m_snap[c] = m_cnt[c];
            if (m_run[c]) m_pc[c] = tick ? 0 : m_pc[c] + 1;
            if (tick) m_cnt[c] = expire ? m_per[c] : m_cnt[c] - 1;
            if (expire) begin
                m_to[c] = 1;
                if (!m_cont[c]) m_run[c] = 0;
            end
            if (sel) begin
                case (rg)
                    0: if (!expire) m_to[c] = 0;
                    1: begin
                        m_ito[c] = wd[0]; m_cont[c] = wd[1]; m_pen[c] = wd[4];
                        m_pre[c] = int'(wd[11:8]);
                        if (wd[2]) begin m_run[c] = 1; m_pc[c] = 0; end
                        else if (wd[3]) m_run[c] = 0;
                    end
                    2: begin
                        m_per[c] = longint'(wd); m_cnt[c] = longint'(wd);
                        m_run[c] = 0; m_pc[c] = 0;
                    end
                    3: m_cmp[c] = longint'(wd);
                    default: ;
                endcase
            end
        end
    endtask

    // One bus clock: drive, step model on the edge, compare shortly after.
    task automatic bus_cycle(input bit cs, input bit wn, input int ch, input int rg,
                             input logic [31:0] wd);
        logic [NCH-1:0] ev;
        chipselect = cs;
        write_n    = wn;
        address    = 5'(ch * 8 + rg);
        writedata  = wd;
        @(posedge clk);
        model_step(reset, cs && !wn, ch, rg, wd);
        #1;
        ev = exp_irqv();
        chk("readdata", readdata, m_rd);
        chk("irq_vec", irq_vec, ev);
        chk("irq", irq, |ev);
        chk("pwm_out", pwm_out, exp_pwm());
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] wd);
        bus_cycle(1'b1, 1'b0, ch, rg, wd);
    endtask

    task automatic rd(input int ch, input int rg);
        bus_cycle(1'b1, 1'b1, ch, rg, 32'd0);
    endtask

    task automatic idle();
        bus_cycle(1'b0, 1'b1, 0, 0, 32'd0);
    endtask

    initial begin
        int first;
        int hi;
        int rch;
        int rrg;
        logic [31:0] rwd;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        idle(); idle();
        chk("rst_irq", irq, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_readdata", readdata, 0);
        reset = 1'b0;
        rd(0, 2); chk("ch0_period_rst", readdata, 99);
        rd(0, 0); chk("ch0_status_rst", readdata, 0);

        // ch1: continuous 10-clk timeout with interrupt
        wr(1, 2, 32'd9); wr(1, 1, 32'h7);
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            idle();
            if (irq_vec[1] && first == 0) first = n;
        end
        chk("ch1_first_timeout", first, 10);
        wr(1, 0, 32'd0);
        chk("ch1_irq_clear", irq_vec[1], 0);
        first = 0;
        for (int n = 1; n <= 10; n++) begin
            idle();
            if (irq_vec[1] && first == 0) first = n;
        end
        chk("ch1_second_timeout", first, 7);
        wr(1, 1, 32'h8); wr(1, 0, 32'd0);

        // ch2: one-shot with prescaler 4, TO clear colliding with the timeout
        wr(2, 2, 32'd3); wr(2, 1, 32'h205);
        for (int n = 1; n <= 15; n++) idle();
        chk("ch2_no_early_to", irq_vec[2], 0);
        wr(2, 0, 32'd0);
        chk("ch2_to_set_wins", irq_vec[2], 1);
        rd(2, 0); chk("ch2_status_stopped", readdata, 1);
        wr(2, 4, 32'd0); rd(2, 4); chk("ch2_counter_reload", readdata, 3);
        wr(2, 0, 32'd0); wr(2, 1, 32'd0);

        // ch0: PWM duty
        wr(0, 2, 32'd7); wr(0, 3, 32'd3); wr(0, 1, 32'h16);
        idle(); idle();
        hi = 0;
        for (int n = 0; n < 32; n++) begin idle(); hi += int'(pwm_out[0]); end
        chk("pwm_3_of_8", hi, 12);
        wr(0, 3, 32'd0); idle(); idle();
        hi = 0;
        for (int n = 0; n < 16; n++) begin idle(); hi += int'(pwm_out[0]); end
        chk("pwm_cmp0_low", hi, 0);
        wr(0, 3, 32'd20); idle(); idle();
        hi = 0;
        for (int n = 0; n < 16; n++) begin idle(); hi += int'(pwm_out[0]); end
        chk("pwm_cmp_gt_period_high", hi, 16);
        wr(0, 1, 32'h8);

        // ch3: snapshot, period reload mid-count, START|STOP
        wr(3, 2, 32'd50); wr(3, 1, 32'h6);
        for (int n = 0; n < 5; n++) idle();
        wr(3, 4, 32'd0); rd(3, 4); chk("ch3_snap", readdata, 45);
        wr(3, 2, 32'd30); rd(3, 0); chk("ch3_period_stops", readdata, 0);
        wr(3, 4, 32'd0); rd(3, 4); chk("ch3_period_reload", readdata, 30);
        wr(3, 1, 32'hE); rd(3, 0); chk("ch3_start_stop", readdata, 2);
        rd(0, 2); chk("iso_ch0_period", readdata, 7);
        rd(1, 2); chk("iso_ch1_period", readdata, 9);
        rd(3, 3); chk("iso_ch3_compare", readdata, 0);

        // All channels running, then reset mid-count
        for (int c = 0; c < NCH; c++) begin
            wr(c, 2, 32'(5 + 4 * c)); wr(c, 3, 32'd3); wr(c, 1, 32'h17);
        end
        for (int n = 0; n < 23; n++) idle();
        reset = 1'b1; idle(); reset = 1'b0;
        chk("rst2_irq", irq, 0);
        chk("rst2_irq_vec", irq_vec, 0);
        chk("rst2_pwm", pwm_out, 0);
        chk("rst2_readdata", readdata, 0);
        for (int c = 0; c < NCH; c++) begin
            wr(c, 4, 32'd0); rd(c, 4); chk("rst2_counter", readdata, 99);
        end

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rch = int'($urandom_range(0, 3));
            rrg = int'($urandom_range(0, 7));
            rwd = $urandom;
            case (rrg)
                1: rwd = (rwd & 32'hFFFF_F0FF) | ($urandom_range(0, 2) << 8);
                2: rwd = $urandom_range(0, 20);
                3: rwd = $urandom_range(0, 25);
                default: ;
            endcase
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            if ($urandom_range(0, 3) == 0) wr(rch, rrg, rwd);
            else rd(rch, rrg);
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
